// File: rtl/rom_arbiter_pkg.sv
// Shared constants and state encoding for the image-ROM arbiter.
package rom_arbiter_pkg;

  localparam int ADDR_W        = 12;
  localparam int RGB_W         = 12;
  localparam int N_REQ_DEF     = 3;
  localparam int MAX_BURST_DEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Modulo-n increment, used for the round-robin pointer after a release.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rom_arbiter_pick.sv
// Round-robin winner search: first requester at or above pointer p, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] p,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx
);

  // Walk from the farthest offset back to p so the nearest hit is kept.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(p) + k) % N]) begin
        win_oh                      = '0;
        win_oh[(int'(p) + k) % N]   = 1'b1;
        win_idx                     = IW'((int'(p) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Burst arbiter sharing one external image ROM among N_REQ sprite/background readers.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [RGB_W-1:0]        rom_rgb,
  output logic [RGB_W-1:0]        rdata,
  output logic [N_REQ-1:0]        rvalid,
  output logic                    busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;

  state_e                  r_state;
  logic [IW-1:0]           r_owner;
  logic [IW-1:0]           r_p;
  logic [CW-1:0]           r_cnt;
  logic [N_REQ-1:0]        r_gnt;
  logic                    r_busy;
  logic [ADDR_W-1:0]       r_rom_addr;
  logic [2:1][N_REQ-1:0]   r_vld_pipe;

  logic [N_REQ-1:0]        w_pick_oh;
  logic [IW-1:0]           w_pick_idx;
  logic                    w_own_req;
  logic                    w_own_last;
  logic [ADDR_W-1:0]       w_own_addr;
  logic                    w_accept;
  logic                    w_release;
  logic [N_REQ-1:0]        w_vld0;
  logic [IW-1:0]           w_next_p;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .p       (r_p),
    .win_oh  (w_pick_oh),
    .win_idx (w_pick_idx)
  );

  assign w_own_req  = req[r_owner];
  assign w_own_last = req_last[r_owner];
  assign w_own_addr = req_addr[r_owner*ADDR_W +: ADDR_W];
  assign w_accept   = (r_state == BURST) && w_own_req;
  // Owner dropping req ends the burst without taking a beat.
  assign w_release  = (r_state == BURST) &&
                      (!w_own_req || w_own_last || (r_cnt == CW'(MAX_BURST - 1)));
  // gnt is one-hot on the owner during BURST, so it doubles as the beat tag.
  assign w_vld0     = r_gnt & {N_REQ{w_accept}};
  assign w_next_p   = IW'(wrap_inc(int'(r_owner), N_REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_p        <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_rom_addr <= '0;
      r_vld_pipe <= '0;
    end else begin
      // Tags keep shifting across releases so trailing beats still land.
      r_vld_pipe <= {r_vld_pipe[1], w_vld0};
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_owner <= w_pick_idx;
            r_gnt   <= w_pick_oh;
            r_busy  <= 1'b1;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_rom_addr <= w_own_addr;
            r_cnt      <= r_cnt + 1'b1;
          end
          if (w_release) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_p     <= w_next_p;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign busy     = r_busy;
  assign rom_addr = r_rom_addr;
  assign rvalid   = r_vld_pipe[2];
  assign rdata    = rom_rgb;

endmodule
